pe_stream_feeder: RTL and testbench
===================================

# pe_stream_feeder

Bus-side transmitter that streams a burst of feature-map or weight words from a global buffer into one PE's input port. It drives the PE load interface: `start_*_load` pulse, `load_full_cloumn`, `*_in`/`*_in_en`. It honours the PE's `fifo_full_*` backpressure and sustains one word per cycle when the PE is not full. One instance sits in front of each PE input (fmap or weight) and is commanded by the array controller.

## Interface
- DATA_WIDTH, 16, data word width (matches PE `feature_in`/`weight_in`)
- ADDR_WIDTH, 8, global-buffer address width
- LEN_WIDTH, 8, burst-length field width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  feeder can accept a command (high only in IDLE)
- cmd_addr  in  ADDR_WIDTH  first buffer address
- cmd_len  in  LEN_WIDTH  number of words in the burst, 0 allowed
- cmd_full_column  in  1  value driven on load_full_cloumn for this burst
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  ADDR_WIDTH  buffer read address
- buf_rd_data  in  DATA_WIDTH  read data, valid the cycle after buf_rd_en
- pe_fifo_full  in  1  PE input FIFO full (`fifo_full_fmap` or `fifo_full_filter`)
- start_load  out  1  one-cycle pulse to PE `start_feature_load`/`start_weight_load`
- load_full_cloumn  out  1  latched cmd_full_column, held until next accept
- data_out  out  DATA_WIDTH  word to PE
- data_out_en  out  1  transfer strobe; a word moves on each rising edge with data_out_en=1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last word transfers

## Operation
- FSM states: IDLE, START, STREAM, DONE.
- IDLE: cmd_ready=1. Accept on cmd_valid & cmd_ready. On accept, latch addr, len, and full_column.
  - len=0: go to DONE.
  - Otherwise: go to START.
- START (1 cycle): start_load=1. The first read is issued in this cycle if len>0. Then go to STREAM.
- STREAM: runs until the issued count equals len and the transferred count equals len, then goes to DONE.
- DONE (1 cycle): done=1, cmd_ready=0. Then go to IDLE.
- Read issue:
  - Uses a 2-entry data FIFO plus an in-flight flag.
  - A read issues when issued < len and (inflight + occupancy − pop_this_cycle) < 2.
  - buf_rd_addr increments mod 2^ADDR_WIDTH after each read; wrap-around is legal.
- Returned data is written into the FIFO on the cycle it is valid.
- data_out is the FIFO head. data_out_en = (occupancy>0) & !pe_fifo_full, combinational from pe_fifo_full.
- Transfer (pop) occurs on a rising edge with data_out_en=1.
- Order is preserved. No word is dropped or duplicated. The FIFO never overflows.
- Counters are LEN_WIDTH wide; len = 2^LEN_WIDTH−1 is the maximum burst.
- cmd_* inputs are ignored outside IDLE.

## Timing
- Reset values (rst=0): state IDLE, busy=0, done=0, start_load=0, buf_rd_en=0, buf_rd_addr=0, data_out=0, data_out_en=0, load_full_cloumn=0, FIFO empty, counters 0. cmd_ready=0 while rst=0 and 1 from the first cycle after release.
- Reset asserted mid-burst: abort immediately. In-flight read data is discarded and no further data_out_en is issued.
- Accept edge T. Cycle T+1: START, start_load=1, buf_rd_en=1 (addr A).
- First data_out_en in cycle T+3. Words transfer every cycle thereafter while pe_fifo_full=0.
- Last transfer at edge E; done=1 in cycle E+1; cmd_ready=1 in cycle E+2.
- Unstalled burst of N words: data_out_en in cycles T+3..T+N+2, done in cycle T+N+3.
- pe_fifo_full rising: data_out_en falls in the same cycle. Reads stop after at most 2 words are buffered or in flight.
- pe_fifo_full falling: transfer resumes in the same cycle, at one word per cycle with no bubble.
- len=0: accept at T, done=1 in cycle T+1. No start_load and no buf_rd_en.

## Test plan
- Burst addr 0x10, len 6, buffer[a]=a+1, pe_fifo_full=0:
  - start_load at T+1.
  - data_out 0x11..0x16 with data_out_en in cycles T+3..T+8.
  - done at T+9.
- Same burst with pe_fifo_full=1 for cycles T+5..T+7:
  - data_out_en is 0 in those cycles.
  - The sequence 0x11..0x16 is complete, in order, with no duplicates.
  - buf_rd_en total is exactly 6.
  - done follows the last transfer by 1 cycle.
- Wrap: addr 0xFE, len 4 → buf_rd_addr FE, FF, 00, 01; data_out matches in order.
- cmd_len=0 → done pulse the cycle after accept. start_load, buf_rd_en, and data_out_en stay 0.
- rst pulled low in the cycle of the 3rd transfer of a len-6 burst:
  - All outputs go to their reset values immediately.
  - After release, a new burst (addr 0x20, len 2) delivers 0x21, 0x22 normally.
- cmd_valid held high across two commands (cmd_full_column 1 then 0):
  - The second command is accepted only in IDLE after done.
  - load_full_cloumn switches from 1 to 0 at the second accept.

Source files
------------

// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder
// Streams a burst of words from a global buffer into one PE input port
// (fmap or weight). It reads the buffer, stages the words in a 2-entry FIFO
// and presents them to the PE one per cycle. The PE FIFO-full signal holds
// transfers back.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   cmd_valid/ready     burst command handshake (ready only in IDLE)
//   cmd_addr/len        first buffer address, word count (0 allowed)
//   cmd_full_column     latched onto load_full_cloumn at accept
//   buf_rd_en/addr      buffer read strobe and address
//   buf_rd_data         read data, valid the cycle after buf_rd_en
//   pe_fifo_full        PE input FIFO full (backpressure)
//   start_load          one-cycle pulse at burst start
//   load_full_cloumn    full-column flag for the current burst
//   data_out/_en        word to the PE and its transfer strobe
//   busy, done          activity flag and end-of-burst pulse
module pe_stream_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_full_column,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  pe_fifo_full,
  output logic                  start_load,
  output logic                  load_full_cloumn,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  full_q, full_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  xfer_q, xfer_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wrPtr_q, rdPtr_q;
  logic [1:0]            count_q, count_d;

  logic       accept;
  logic       pop;
  logic       rdEn;
  logic [2:0] slotsUsed;

  // Ready is forced low while reset is held, so no command can be seen
  // as accepted during reset.
  assign cmd_ready        = (state_q == IDLE) && rst;
  assign accept           = cmd_valid && cmd_ready;
  assign data_out         = mem_q[rdPtr_q];
  assign data_out_en      = (count_q != 2'd0) && !pe_fifo_full;
  assign pop              = data_out_en;
  assign buf_rd_en        = rdEn;
  assign buf_rd_addr      = addr_q;
  assign start_load       = (state_q == START);
  assign load_full_cloumn = full_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);

  // A word popped this cycle frees its slot in time for a read issued now,
  // which is what sustains one word per cycle without FIFO overflow.
  assign slotsUsed = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    full_d   = full_q;
    rdEn     = 1'b0;
    if ((state_q == START) || (state_q == STREAM)) begin
      rdEn = (issued_q < len_q) && (slotsUsed < 3'd2);
    end
    issued_d = issued_q + LEN_WIDTH'(rdEn);
    xfer_d   = xfer_q + LEN_WIDTH'(pop);
    count_d  = count_q + {1'b0, inflight_q} - {1'b0, pop};
    if (rdEn) begin
      addr_d = addr_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          full_d   = cmd_full_column;
          issued_d = '0;
          xfer_d   = '0;
          state_d  = (cmd_len == '0) ? DONE : START;
        end
      end
      START: state_d = STREAM;
      STREAM: begin
        if ((issued_d == len_q) && (xfer_d == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      full_q     <= 1'b0;
      issued_q   <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wrPtr_q    <= 1'b0;
      rdPtr_q    <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      full_q     <= full_d;
      issued_q   <= issued_d;
      xfer_q     <= xfer_d;
      inflight_q <= rdEn;
      count_q    <= count_d;
      // Read data is valid exactly one cycle after its strobe.
      if (inflight_q) begin
        mem_q[wrPtr_q] <= buf_rd_data;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// tb_pe_stream_feeder
// Self-checking bench for pe_stream_feeder. A buffer model returns
// buffer[a] = a+1 one cycle after each read. Expected read addresses and
// words are queued when a command is driven and compared as the DUT
// produces them.
module tb_pe_stream_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_full_column = 1'b0;
  logic        buf_rd_en;
  logic [7:0]  buf_rd_addr;
  logic [15:0] buf_rd_data = '0;
  logic        pe_fifo_full = 1'b0;
  logic        start_load;
  logic        load_full_cloumn;
  logic [15:0] data_out;
  logic        data_out_en;
  logic        busy;
  logic        done;

  pe_stream_feeder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_full_column(cmd_full_column),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .pe_fifo_full(pe_fifo_full), .start_load(start_load),
    .load_full_cloumn(load_full_cloumn), .data_out(data_out),
    .data_out_en(data_out_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Global buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= {8'h00, buf_rd_addr} + 16'd1;
  end

  logic [15:0] expWords[$];
  logic [7:0]  expAddrs[$];
  int errors = 0;
  int checks = 0;

  int acceptCyc = 0, startCyc = 0, firstXferCyc = 0, lastXferCyc = 0, doneCyc = 0;
  int burstReads = 0, burstXfers = 0, burstStarts = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid && cmd_ready) begin
        burstReads  = 0;
        burstXfers  = 0;
        burstStarts = 0;
        acceptCyc   = cyc;
      end
      if (start_load) begin
        burstStarts++;
        startCyc = cyc;
      end
      if (buf_rd_en) begin
        burstReads++;
        if (expAddrs.size() == 0) checkOutput("extra_read", 32'(buf_rd_addr), 32'hFFFF_FFFF);
        else checkOutput("rd_addr", 32'(buf_rd_addr), 32'(expAddrs.pop_front()));
      end
      if (pe_fifo_full) checkOutput("en_while_full", 32'(data_out_en), 32'd0);
      if (data_out_en) begin
        if (burstXfers == 0) firstXferCyc = cyc;
        burstXfers++;
        lastXferCyc = cyc;
        if (expWords.size() == 0) checkOutput("extra_word", 32'(data_out), 32'hFFFF_FFFF);
        else checkOutput("data_out", 32'(data_out), 32'(expWords.pop_front()));
      end
      if (done) doneCyc = cyc;
    end
  end

  task automatic pushExpected(input logic [7:0] addr, input logic [7:0] len);
    logic [7:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 8'(i);
      expAddrs.push_back(a);
      expWords.push_back({8'h00, a} + 16'd1);
    end
  endtask

  // Runs one burst; pe_fifo_full is high for accept-relative cycles
  // stallFrom..stallTo. expDoneOff is the expected done cycle offset.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] len,
                               input logic full, input int stallFrom,
                               input int stallTo, input int expDoneOff);
    int a;
    bit got;
    a = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_full_column = full;
    pushExpected(addr, len);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; a = cyc; break; end
    end
    checkOutput("accepted", 32'(got), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 0;
    for (int k = 1; k < 400; k++) begin
      pe_fifo_full = (k >= stallFrom) && (k <= stallTo);
      @(negedge clk);
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
    end
    pe_fifo_full = 1'b0;
    #1;
    checkOutput("done_seen", 32'(got), 32'd1);
    checkOutput("done_time", 32'(doneCyc - a), 32'(expDoneOff));
    checkOutput("lfc_held", 32'(load_full_cloumn), 32'(full));
    if (len == 8'd0) begin
      checkOutput("zlen_starts", 32'(burstStarts), 32'd0);
      checkOutput("zlen_reads", 32'(burstReads), 32'd0);
      checkOutput("zlen_xfers", 32'(burstXfers), 32'd0);
    end else begin
      checkOutput("start_time", 32'(startCyc - a), 32'd1);
      checkOutput("starts", 32'(burstStarts), 32'd1);
      checkOutput("first_xfer", 32'(firstXferCyc - a), 32'd3);
      checkOutput("done_after_last", 32'(doneCyc - lastXferCyc), 32'd1);
      checkOutput("reads", 32'(burstReads), 32'(len));
      checkOutput("xfers", 32'(burstXfers), 32'(len));
    end
    checkOutput("sb_empty", 32'(expWords.size() + expAddrs.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_start"}, 32'(start_load), 32'd0);
    checkOutput({tag, "_rden"}, 32'(buf_rd_en), 32'd0);
    checkOutput({tag, "_rdaddr"}, 32'(buf_rd_addr), 32'd0);
    checkOutput({tag, "_dout"}, 32'(data_out), 32'd0);
    checkOutput({tag, "_douten"}, 32'(data_out_en), 32'd0);
    checkOutput({tag, "_lfc"}, 32'(load_full_cloumn), 32'd0);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    int a2;
    bit got;
    a = 0;
    a2 = 0;
    $display("[TB] start");
    #12;
    checkResetOutputs("rst");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Unstalled, stalled, wrap-around and zero-length bursts.
    applyStimulus(8'h10, 8'd6, 1'b1, 0, -1, 9);
    applyStimulus(8'h10, 8'd6, 1'b0, 5, 7, 12);
    checkOutput("stall_last_xfer", 32'(lastXferCyc - acceptCyc), 32'd11);
    applyStimulus(8'hFE, 8'd4, 1'b1, 0, -1, 7);
    applyStimulus(8'h33, 8'd0, 1'b1, 0, -1, 1);

    // Reset in the cycle of the third transfer of a 6-word burst.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 8'h10; cmd_len = 8'd6; cmd_full_column = 1'b1;
    pushExpected(8'h10, 8'd6);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; a = cyc; break; end
    end
    checkOutput("rst_burst_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_cycle", 32'(cyc - a), 32'd5);
    checkOutput("rst_xfers_before", 32'(burstXfers), 32'd2);
    checkOutput("rst_en_before", 32'(data_out_en), 32'd1);
    rst = 1'b0;
    #1;
    checkResetOutputs("midrst");
    expWords.delete();
    expAddrs.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    applyStimulus(8'h20, 8'd2, 1'b0, 0, -1, 5);

    // cmd_valid held across two commands.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 8'h40; cmd_len = 8'd3; cmd_full_column = 1'b1;
    pushExpected(8'h40, 8'd3);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; a = cyc; break; end
    end
    checkOutput("hold_accept1", 32'(got), 32'd1);
    @(posedge clk); #1;
    cmd_addr = 8'h50; cmd_len = 8'd2; cmd_full_column = 1'b0;
    pushExpected(8'h50, 8'd2);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; a2 = cyc; break; end
    end
    #1;
    checkOutput("hold_accept2", 32'(got), 32'd1);
    checkOutput("hold_acc2_after_done", 32'(a2 - doneCyc), 32'd1);
    checkOutput("hold_done1_time", 32'(doneCyc - a), 32'd6);
    checkOutput("hold_lfc_before", 32'(load_full_cloumn), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("hold_lfc_after", 32'(load_full_cloumn), 32'd0);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    #1;
    checkOutput("hold_done2", 32'(got), 32'd1);
    checkOutput("hold_done2_time", 32'(doneCyc - a2), 32'd5);
    checkOutput("hold_sb_empty", 32'(expWords.size() + expAddrs.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
